layer_feeder: RTL and testbench

Inter-layer stage that sits directly upstream of a layer of `neuron_no_ReLU` instances. It accepts the previous layer's 2×dataWidth accumulator results as a valid/ready stream, requantizes each one (arithmetic shift, optional ReLU, saturation to dataWidth) into a local buffer, and then replays the buffer one word per cycle on the shared neuron input bus. While replaying it drives the layer's `freeze` line low for exactly `numInputs` cycles. It pulses `layer_done` when every downstream `out_n` is final.

---
 rtl/fnn_pkg.sv | 15 +
 rtl/requant_sat.sv | 32 +++
 rtl/layer_feeder.sv | 122 ++++++++++++
 tb/tb_layer_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// Shared types for the inter-layer feeder: FSM state encoding and the
// activation selector strings accepted by the requantizer.
package fnn_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam ACT_RELU = "relu";
  localparam ACT_NONE = "none";

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic shift of a wide accumulator word,
// optional ReLU clamp, then saturation into the neuron input width.
module requant_sat
  import fnn_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int accWidth  = 2 * dataWidth,
  parameter int shiftBits = 12,
  parameter     actType   = ACT_RELU
) (
  input  logic [accWidth-1:0]  acc,
  output logic [dataWidth-1:0] q
);

  localparam logic signed [accWidth-1:0] MAXV =
    {{(accWidth - dataWidth + 1){1'b0}}, {(dataWidth - 1){1'b1}}};
  localparam logic signed [accWidth-1:0] MINV =
    {{(accWidth - dataWidth + 1){1'b1}}, {(dataWidth - 1){1'b0}}};
  localparam bit DO_RELU = (actType == ACT_RELU);

  logic signed [accWidth-1:0] t;

  // The shift floors toward -inf, so small negatives become -1, not 0.
  always_comb begin
    t = $signed(acc) >>> shiftBits;
    if (DO_RELU && (t < 0)) t = '0;
    if (t > MAXV)      q = MAXV[dataWidth-1:0];
    else if (t < MINV) q = MINV[dataWidth-1:0];
    else               q = t[dataWidth-1:0];
  end

endmodule

// File: rtl/layer_feeder.sv
// Buffers one frame of requantized words from the previous layer, then
// replays it to the downstream neurons with freeze held low per word.
module layer_feeder
  import fnn_pkg::*;
#(
  parameter int numInputs = 784,
  parameter int dataWidth = 16,
  parameter int accWidth  = 2 * dataWidth,
  parameter int shiftBits = 12,
  parameter     actType   = ACT_RELU
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [accWidth-1:0]  in_data,
  input  logic                 go,
  output logic                 freeze,
  output logic [dataWidth-1:0] myinput,
  output logic                 layer_done
);

  localparam int CW = $clog2(numInputs + 1);
  localparam int AW = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam logic [CW-1:0] LAST = CW'(numInputs - 1);
  localparam logic [CW-1:0] FULL = CW'(numInputs);

  state_t state, state_next;
  logic [CW-1:0] load_cnt, load_cnt_next;
  logic [CW-1:0] strm_cnt, strm_cnt_next;
  logic freeze_next, done_next, wr_en, rd_en;
  logic [AW-1:0] rd_addr;
  logic [dataWidth-1:0] q;
  logic [dataWidth-1:0] mem [numInputs];

  requant_sat #(
    .dataWidth(dataWidth),
    .accWidth (accWidth),
    .shiftBits(shiftBits),
    .actType  (actType)
  ) u_requant (
    .acc(in_data),
    .q  (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      load_cnt   <= '0;
      strm_cnt   <= '0;
      freeze     <= 1'b1;
      layer_done <= 1'b0;
    end else begin
      state      <= state_next;
      load_cnt   <= load_cnt_next;
      strm_cnt   <= strm_cnt_next;
      freeze     <= freeze_next;
      layer_done <= done_next;
    end
  end

  // strm_cnt always holds the index of the next word to fetch.
  always_comb begin
    state_next    = state;
    load_cnt_next = load_cnt;
    strm_cnt_next = strm_cnt;
    freeze_next   = 1'b1;
    done_next     = 1'b0;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = strm_cnt[AW-1:0];
    in_ready      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en         = 1'b1;
          load_cnt_next = load_cnt + 1'b1;
          if (load_cnt == LAST) state_next = WAIT;
        end
      end
      WAIT: begin
        rd_addr = '0;
        if (go) begin
          rd_en         = 1'b1;
          freeze_next   = 1'b0;
          strm_cnt_next = CW'(1);
          state_next    = STREAM;
        end
      end
      STREAM: begin
        if (strm_cnt == FULL) begin
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          rd_en         = 1'b1;
          freeze_next   = 1'b0;
          strm_cnt_next = strm_cnt + 1'b1;
        end
      end
      DONE: begin
        load_cnt_next = '0;
        strm_cnt_next = '0;
        state_next    = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[load_cnt[AW-1:0]] <= q;
  end

  // The output register doubles as the RAM read port, so buf[0] lands on
  // myinput on the same edge that samples go.
  always_ff @(posedge clk) begin
    if (rst)        myinput <= '0;
    else if (rd_en) myinput <= mem[rd_addr];
    else            myinput <= '0;
  end

endmodule

// File: tb/tb_layer_feeder.sv
// Self-checking bench: two feeders (actType none / relu) share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_layer_feeder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        go = 1'b0;
  logic [31:0] in_data = '0;

  logic        ready_n, freeze_n, done_n;
  logic [15:0] my_n;
  logic        ready_r, freeze_r, done_r;
  logic [15:0] my_r;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  layer_feeder #(
    .numInputs(N), .dataWidth(16), .accWidth(32), .shiftBits(12), .actType("none")
  ) dut_none (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_n),
    .in_data(in_data), .go(go), .freeze(freeze_n), .myinput(my_n),
    .layer_done(done_n)
  );

  layer_feeder #(
    .numInputs(N), .dataWidth(16), .accWidth(32), .shiftBits(12), .actType("relu")
  ) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_r),
    .in_data(in_data), .go(go), .freeze(freeze_r), .myinput(my_r),
    .layer_done(done_r)
  );

  // Requantization from its arithmetic definition: floor-divide, clamp.
  function automatic logic [15:0] rq_model(input logic [31:0] w, input bit relu);
    longint v, t;
    logic [63:0] bits;
    v = longint'($signed(w));
    if (v >= 0) t = v / 4096;
    else        t = -((-v + 4095) / 4096);
    if (relu && t < 0) t = 0;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    bits = t;
    return bits[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL timeout %s: got no progress, want phase change", name);
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit g,
                               input bit r);
    in_valid = v;
    in_data  = d;
    go       = g;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return $urandom;
      3:       return $urandom & 32'h07FF_FFFF;
      4:       return $urandom | 32'hF800_0000;
      default: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_1000;
    endcase
  endfunction

  // Reference model: words loaded so far, and the number of cycles since go
  // was accepted (age 1..N = word age-1 on the bus, age N+1 = done cycle).
  logic [15:0] mb_n [N];
  logic [15:0] mb_r [N];
  int nloaded = 0;
  int age = -1;

  always @(posedge clk) begin
    if (rst) begin
      nloaded = 0;
      age = -1;
    end else if (age >= 0) begin
      if (age == N + 1) begin
        age = -1;
        nloaded = 0;
      end else begin
        age++;
      end
    end else if (nloaded < N) begin
      if (in_valid) begin
        mb_n[nloaded] = rq_model(in_data, 1'b0);
        mb_r[nloaded] = rq_model(in_data, 1'b1);
        nloaded++;
      end
    end else if (go) begin
      age = 1;
    end
  end

  logic [15:0] cap_n [8];
  logic [15:0] cap_r [8];
  int ncap_n = 0, ncap_r = 0, dones_n = 0, dones_r = 0;

  always @(negedge clk) begin
    if (check_en) begin
      logic [15:0] en, er;
      bit streaming;
      streaming = (age >= 1) && (age <= N);
      en = '0;
      er = '0;
      if (streaming) begin
        en = mb_n[age-1];
        er = mb_r[age-1];
      end
      checkOutput("ready_none",  {31'b0, ready_n},  {31'b0, (age < 0) && (nloaded < N)});
      checkOutput("ready_relu",  {31'b0, ready_r},  {31'b0, (age < 0) && (nloaded < N)});
      checkOutput("freeze_none", {31'b0, freeze_n}, {31'b0, !streaming});
      checkOutput("freeze_relu", {31'b0, freeze_r}, {31'b0, !streaming});
      checkOutput("data_none",   {16'b0, my_n},     {16'b0, en});
      checkOutput("data_relu",   {16'b0, my_r},     {16'b0, er});
      checkOutput("done_none",   {31'b0, done_n},   {31'b0, age == N + 1});
      checkOutput("done_relu",   {31'b0, done_r},   {31'b0, age == N + 1});
      if (!freeze_n && ncap_n < 8) begin cap_n[ncap_n] = my_n; ncap_n++; end
      if (!freeze_r && ncap_r < 8) begin cap_r[ncap_r] = my_r; ncap_r++; end
      if (done_n) dones_n++;
      if (done_r) dones_r++;
    end
  end

  logic [31:0] vec [N];
  logic [15:0] lit_n [N];
  logic [15:0] lit_r [N];

  initial begin
    int k, budget, d0;
    vec[0] = 32'h0000_3000; lit_n[0] = 16'h0003; lit_r[0] = 16'h0003;
    vec[1] = 32'h7FFF_FFFF; lit_n[1] = 16'h7FFF; lit_r[1] = 16'h7FFF;
    vec[2] = 32'hFFFF_F000; lit_n[2] = 16'hFFFF; lit_r[2] = 16'h0000;
    vec[3] = 32'h8000_0000; lit_n[3] = 16'h8000; lit_r[3] = 16'h0000;

    applyStimulus(0, '0, 0, 1);
    check_en = 1'b1;
    checkOutput("rst_freeze", {31'b0, freeze_n}, 32'd1);
    checkOutput("rst_myinput", {16'b0, my_n}, 32'd0);
    checkOutput("rst_done", {31'b0, done_n}, 32'd0);
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 0);
    checkOutput("ready_after_rst", {31'b0, ready_n}, 32'd1);

    // Directed frame: valid every other cycle, long WAIT, then one go pulse.
    ncap_n = 0; ncap_r = 0; dones_n = 0; dones_r = 0;
    k = 0;
    for (int c = 0; c < 2 * N; c++) begin
      if (c % 2 == 1) begin
        applyStimulus(1, vec[k], 0, 0);
        k++;
      end else begin
        applyStimulus(0, $urandom, 0, 0);
      end
    end
    repeat (10) applyStimulus($urandom_range(0, 1), $urandom, 0, 0);
    applyStimulus(0, '0, 1, 0);
    repeat (N + 3) applyStimulus(0, '0, 0, 0);
    checkOutput("lit_stream_len_none", ncap_n, N);
    checkOutput("lit_stream_len_relu", ncap_r, N);
    checkOutput("lit_done_count_none", dones_n, 1);
    checkOutput("lit_done_count_relu", dones_r, 1);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("lit_none_%0d", i), {16'b0, cap_n[i]}, {16'b0, lit_n[i]});
      checkOutput($sformatf("lit_relu_%0d", i), {16'b0, cap_r[i]}, {16'b0, lit_r[i]});
    end

    // Reset in the second stream cycle aborts the frame without layer_done.
    for (int i = 0; i < N; i++) applyStimulus(1, rand_word(), 0, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 0, 0);
    d0 = dones_n;
    applyStimulus(0, '0, 0, 1);
    checkOutput("abort_freeze", {31'b0, freeze_n}, 32'd1);
    checkOutput("abort_myinput", {16'b0, my_n}, 32'd0);
    checkOutput("abort_ready", {31'b0, ready_n}, 32'd1);
    checkOutput("abort_done", {31'b0, done_n}, 32'd0);
    applyStimulus(0, '0, 0, 0);
    repeat (N + 2) applyStimulus(0, '0, 0, 0);
    checkOutput("abort_no_done_pulse", dones_n, d0);

    // Randomized frames, some with go held high through the load.
    for (int f = 0; f < 10; f++) begin
      bit b2b;
      b2b = ($urandom_range(0, 1) != 0);
      budget = 0;
      while (nloaded < N && budget < 100) begin
        applyStimulus($urandom_range(0, 1), rand_word(),
                      b2b ? 1'b1 : 1'($urandom_range(0, 1)), 0);
        budget++;
      end
      if (budget >= 100) timeoutFail("load");
      if (!b2b) repeat ($urandom_range(0, 3)) applyStimulus($urandom_range(0, 1), $urandom, 0, 0);
      budget = 0;
      while (age < 0 && budget < 20) begin
        applyStimulus($urandom_range(0, 1), $urandom, 1, 0);
        budget++;
      end
      if (budget >= 20) timeoutFail("go");
      budget = 0;
      while (!(age < 0 && nloaded == 0) && budget < 20) begin
        applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 0);
        budget++;
      end
      if (budget >= 20) timeoutFail("stream");
    end

    repeat (2) applyStimulus(0, '0, 0, 0);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
